// File: rtl/mcu0_sequencer_if.sv
// Byte-wide memory bus between mcu0_sequencer (master) and the external memory (slave).
// One byte per req/ack transaction; ack may arrive in the same cycle req rises.
interface mcu0_sequencer_if;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/mcu0_sequencer.sv
// Multi-cycle controller for the 16-bit accumulator machine over a byte-wide big-endian memory.
// Optional MCU0_HALT_EN: opcode F halts the machine instead of acting as a NOP.
module mcu0_sequencer #(
    parameter logic [11:0] RESET_PC = 12'h000,
    parameter int          MAX_WAIT = 255
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 run,
    mcu0_sequencer_if.master     bus,
    output logic [2:0]           alu_op,
    output logic [15:0]          alu_a,
    output logic [15:0]          alu_b,
    input  logic [15:0]          alu_y,
    output logic [11:0]          pc,
    output logic [15:0]          acc,
    output logic                 sw_n,
    output logic                 sw_z,
    output logic                 busy,
    output logic                 halted,
    output logic                 bus_err
);
    typedef enum logic [3:0] {IDLE, F0, F1, DEC, R0, R1, EX, W0, W1, HALT} state_t;

    localparam logic [3:0]  OP_LD  = 4'h0;
    localparam logic [3:0]  OP_ADD = 4'h1;
    localparam logic [3:0]  OP_JMP = 4'h2;
    localparam logic [3:0]  OP_ST  = 4'h3;
    localparam logic [3:0]  OP_CMP = 4'h4;
    localparam logic [3:0]  OP_JEQ = 4'h5;
    localparam logic [15:0] WD_LAST = 16'(MAX_WAIT - 1);

    state_t      state, state_nxt;
    logic [15:0] ir, m, wait_cnt;
    logic [3:0]  opc;
    logic [11:0] c;
    logic        mem_state, wd_fire, take_jump;
    state_t      boundary;

    assign opc       = ir[15:12];
    assign c         = ir[11:0];
    assign mem_state = (state == F0) || (state == F1) || (state == R0) ||
                       (state == R1) || (state == W0) || (state == W1);
    assign take_jump = (opc == OP_JMP) || ((opc == OP_JEQ) && sw_z);
    assign boundary  = run ? F0 : IDLE;
    assign wd_fire   = (MAX_WAIT != 0) && mem_state && !bus.mem_ack && (wait_cnt == WD_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (run) state_nxt = F0;
            F0:   if (bus.mem_ack) state_nxt = F1;
            F1:   if (bus.mem_ack) state_nxt = DEC;
            DEC: begin
                case (opc)
                    OP_LD, OP_ADD, OP_CMP: state_nxt = R0;
                    OP_ST:                 state_nxt = W0;
`ifdef MCU0_HALT_EN
                    4'hF:                  state_nxt = HALT;
`endif
                    default:               state_nxt = boundary;
                endcase
            end
            R0:   if (bus.mem_ack) state_nxt = R1;
            R1:   if (bus.mem_ack) state_nxt = EX;
            EX:   state_nxt = boundary;
            W0:   if (bus.mem_ack) state_nxt = W1;
            W1:   if (bus.mem_ack) state_nxt = boundary;
            HALT: state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
        // A stalled request overrides normal sequencing and parks the machine.
        if (wd_fire) state_nxt = HALT;
    end

    always_comb begin
        bus.mem_req   = mem_state;
        bus.mem_we    = (state == W0) || (state == W1);
        bus.mem_addr  = 12'h000;
        bus.mem_wdata = 8'h00;
        case (state)
            F0:      bus.mem_addr = pc;
            F1:      bus.mem_addr = pc + 12'd1;
            R0, W0:  bus.mem_addr = c;
            R1, W1:  bus.mem_addr = c + 12'd1;
            default: bus.mem_addr = 12'h000;
        endcase
        if (state == W0) bus.mem_wdata = acc[15:8];
        if (state == W1) bus.mem_wdata = acc[7:0];
    end

    assign alu_op = (opc == OP_CMP) ? 3'b001 : 3'b000;
    assign alu_a  = acc;
    assign alu_b  = m;
    assign busy   = (state != IDLE) && (state != HALT);
    assign halted = (state == HALT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            ir       <= '0;
            m        <= '0;
            acc      <= '0;
            sw_n     <= 1'b0;
            sw_z     <= 1'b0;
            bus_err  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bus_err <= bus_err | wd_fire;
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (mem_state)
                wait_cnt <= wait_cnt + 16'd1;
            if (bus.mem_ack) begin
                case (state)
                    F0:      ir[15:8] <= bus.mem_rdata;
                    F1:      ir[7:0]  <= bus.mem_rdata;
                    R0:      m[15:8]  <= bus.mem_rdata;
                    R1:      m[7:0]   <= bus.mem_rdata;
                    default: ;
                endcase
            end
            if (state == DEC)
                pc <= take_jump ? c : pc + 12'd2;
            if (state == EX) begin
                case (opc)
                    OP_LD:  acc <= m;
                    OP_ADD: acc <= alu_y;
                    OP_CMP: begin
                        sw_n <= $signed(acc) < $signed(m);
                        sw_z <= (acc == m);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
